sobol_gen_param: RTL and testbench
==================================

SOBOL_GEN_PARAM -- requirements
Module: sobol_gen_param

Interface
- REQ-001 SHALL have parameter W, default 6: output word width and index width; sequence period is 2^W.
- REQ-002 SHALL have parameter D, default 2: number of independent dimensions (channels).
- REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
- REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
- REQ-005 SHALL have port en, input, 1 bit: block enable; low synchronously clears the block to idle.
- REQ-006 SHALL have port start, input, 1 bit: single-cycle pulse that loads the configuration and begins a run.
- REQ-007 SHALL have port mode, input, 2 bits: bit0 = 1 for Gray-code ordering, 0 for natural ordering; bit1 = 1 for odd indices only (stride 2), 0 for every index.
- REQ-008 SHALL have port len, input, W bits: number of points per run; 0 means free-running.
- REQ-009 SHALL have port dir, input, D*W*W bits: direction numbers; dimension d, bit k occupies bits [(d*W+k)*W +: W].
- REQ-010 SHALL have port out_data, output, D*W bits: one sample per dimension; dimension d occupies bits [d*W +: W].
- REQ-011 SHALL have port out_idx, output, W bits: sequence index of the current out_data.
- REQ-012 SHALL have port out_valid, output, 1 bit: out_data and out_idx are valid.
- REQ-013 SHALL have port out_ready, input, 1 bit: consumer accepts the sample.
- REQ-014 SHALL have ports busy and done, output, 1 bit each: busy = run active; done = one-cycle pulse when the last point of a bounded run is accepted.

Function
- REQ-015 SHALL implement FSM states IDLE, RUN.
  - IDLE -> RUN on start while en=1.
  - RUN -> IDLE when the len-th point is accepted (len != 0), or when en=0.
- REQ-016 SHALL, on start, register mode, len and dir, and set the index to 1 if mode[1]=1, else 0.
- REQ-017 SHALL compute each sample as x_d(n) = XOR over k of (g[k] ? v_{d,k} : 0).
  - g = n when mode[0]=0; g = n ^ (n>>1) when mode[0]=1.
  - All arithmetic is W bits wide; no carry out.
- REQ-018 SHALL assert out_valid in the cycle after start is accepted, with the first sample registered (latency 1).
- REQ-019 SHALL hold out_data, out_idx and out_valid stable while out_valid=1 and out_ready=0.
- REQ-020 SHALL advance the index by 1 (or by 2 when mode[1]=1) on each cycle with out_valid & out_ready, and present the next sample in the following cycle with out_valid still 1 (one sample per cycle under continuous ready).
- REQ-021 SHALL wrap the index modulo 2^W: 2^W-1 -> 0 in stride-1 mode; 2^W-1 -> 1 in stride-2 mode.
- REQ-022 SHALL count accepted points, assert done together with the acceptance of point len, then deassert out_valid and busy in the following cycle.
- REQ-023 SHALL treat start during RUN as a restart: reload the configuration and index; the pending sample is discarded without done.
- REQ-024 SHALL give en=0 priority over start. In the same cycle all outputs clear to their reset values, the state returns to IDLE, and registered configuration is kept.
- REQ-025 SHALL ignore out_ready when out_valid=0, and SHALL ignore changes on dir, mode and len outside a start cycle.

Reset
- REQ-026 SHALL, on rst low, immediately force:
  - state to IDLE;
  - out_data, out_idx and the point counter to 0;
  - out_valid, busy and done to 0;
  - registered dir, mode and len to 0.
- REQ-027 SHALL resume only on a start after rst deasserts; reset mid-run abandons the run without done.

Structure
- REQ-028 SHALL place the FSM state encoding and the mode bit positions (MODE_GRAY, MODE_ODD) in the shared package sobol_pkg.
- REQ-029 SHALL instantiate D copies of sub-module sobol_lane.
  - Inputs: W-bit ordering word g and that lane's W*W direction numbers.
  - Output: combinational W-bit XOR result, registered in the parent.

Verification
- REQ-030 SHALL cover natural mode: W=6, dimension 0 dir v_k = 1<<(5-k), mode=00, len=4, ready=1.
  - Required: out_idx 0,1,2,3 with out_data[0] 0,32,16,48.
  - done pulses with the fourth acceptance; out_valid low afterwards.
- REQ-031 SHALL cover Gray mode: same dir, mode=01, len=4.
  - Required: out_data[0] 0,32,48,16.
- REQ-032 SHALL cover odd stride with wrap: mode=10, len=0, ready=1 for 33 accepts.
  - Required: out_idx 1,3,...,63, then 1.
  - No done pulse; busy stays 1.
- REQ-033 SHALL cover backpressure: out_ready held 0 for 5 cycles mid-run.
  - Required: out_data and out_idx frozen; no sample lost or duplicated on release.
- REQ-034 SHALL cover abort conditions:
  - en=0 mid-run: outputs 0 and IDLE next cycle.
  - rst low mid-run: outputs 0 immediately.
  - start during RUN: index restarts at 0 (or 1), no done.

Source files
------------

// File: rtl/sobol_pkg.sv
// Shared definitions for the Sobol sequence generator.
//   state_t   : run-control FSM encoding (IDLE, RUN)
//   MODE_GRAY : mode bit selecting Gray-code ordering of the index
//   MODE_ODD  : mode bit selecting odd indices only (stride 2)
package sobol_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int MODE_GRAY = 0;
  localparam int MODE_ODD  = 1;

endpackage

// File: rtl/sobol_gen_param_if.sv
// Sample stream from the generator to its consumer.
//   out_data  : D samples, dimension d at [d*W +: W]
//   out_idx   : sequence index that produced out_data
//   out_valid : out_data/out_idx are valid
//   out_ready : consumer accepts the sample
// Handshake: a sample transfers on a rising edge where out_valid and
// out_ready are both 1. While out_valid=1 and out_ready=0 the source holds
// out_data, out_idx and out_valid stable; out_ready is ignored while
// out_valid=0.
interface sobol_gen_param_if #(
  parameter int W = 6,
  parameter int D = 2
);
  logic [D*W-1:0] out_data;
  logic [W-1:0]   out_idx;
  logic           out_valid;
  logic           out_ready;

  modport master (output out_data, output out_idx, output out_valid, input out_ready);
  modport slave  (input out_data, input out_idx, input out_valid, output out_ready);
endinterface

// File: rtl/sobol_lane.sv
// One Sobol dimension: XOR of the direction numbers selected by the set bits
// of the ordering word g. Purely combinational; the parent registers x.
//   g   : W-bit ordering word (index or its Gray code)
//   dir : W direction numbers, number k at [k*W +: W]
//   x   : W-bit sample
module sobol_lane #(
  parameter int W = 6
) (
  input  logic [W-1:0]   g,
  input  logic [W*W-1:0] dir,
  output logic [W-1:0]   x
);

  always_comb begin
    x = '0;
    for (int k = 0; k < W; k++) begin
      if (g[k]) x = x ^ dir[k*W +: W];
    end
  end

endmodule

// File: rtl/sobol_gen_param.sv
// Parameterised multi-dimensional Sobol sequence generator.
//   clk, rst   : clock, asynchronous active-low reset
//   en         : block enable; low clears the run (config registers kept)
//   start      : load mode/len/dir and begin a run (also restarts a run)
//   mode       : [MODE_GRAY] Gray ordering, [MODE_ODD] odd indices only
//   len        : points per run, 0 = free-running
//   dir        : direction numbers, dim d bit k at [(d*W+k)*W +: W]
//   stream     : sample stream (master side)
//   busy, done : run active; one-cycle pulse on acceptance of the last point
//   dbg_state  : current FSM state
module sobol_gen_param
  import sobol_pkg::*;
#(
  parameter int W = 6,
  parameter int D = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 start,
  input  logic [1:0]           mode,
  input  logic [W-1:0]         len,
  input  logic [D*W*W-1:0]     dir,
  sobol_gen_param_if.master    stream,
  output logic                 busy,
  output logic                 done,
  output state_t               dbg_state
);

  localparam logic [W-1:0] ONE = W'(1);
  localparam logic [W-1:0] TWO = W'(2);

  state_t             state_q, state_d;
  logic [1:0]         mode_q;
  logic [W-1:0]       len_q;
  logic [D*W*W-1:0]   dir_q;
  logic [W-1:0]       idx_q;
  logic [W-1:0]       cnt_q;
  logic [D*W-1:0]     data_q;
  logic               valid_q;

  logic               accept;
  logic               last;
  logic [W-1:0]       stride;
  logic [W-1:0]       start_idx;
  logic [W-1:0]       sel_idx;
  logic               sel_gray;
  logic [D*W*W-1:0]   sel_dir;
  logic [W-1:0]       g;
  logic [D*W-1:0]     lane_x;

  assign accept    = valid_q & stream.out_ready;
  // cnt_q counts points already accepted, so this acceptance is point cnt_q+1.
  assign last      = (len_q != '0) && ((cnt_q + ONE) == len_q);
  assign stride    = mode_q[MODE_ODD] ? TWO : ONE;
  assign start_idx = mode[MODE_ODD] ? ONE : '0;

  // The lanes always compute the sample that will be registered next: on a
  // start it comes from the incoming config, otherwise from the stored one.
  assign sel_idx  = start ? start_idx : (idx_q + stride);
  assign sel_gray = start ? mode[MODE_GRAY] : mode_q[MODE_GRAY];
  assign sel_dir  = start ? dir : dir_q;
  assign g        = sel_gray ? (sel_idx ^ (sel_idx >> 1)) : sel_idx;

  for (genvar d = 0; d < D; d++) begin : g_lane
    sobol_lane #(.W(W)) u_lane (
      .g   (g),
      .dir (sel_dir[d*W*W +: W*W]),
      .x   (lane_x[d*W +: W])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!en)                                         state_d = IDLE;
    else if (start)                                  state_d = RUN;
    else if ((state_q == RUN) && accept && last)     state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q  <= '0;
      len_q   <= '0;
      dir_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else if (!en) begin
      idx_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else if (start) begin
      mode_q  <= mode;
      len_q   <= len;
      dir_q   <= dir;
      idx_q   <= start_idx;
      cnt_q   <= '0;
      data_q  <= lane_x;
      valid_q <= 1'b1;
    end else if (accept) begin
      if (last) begin
        valid_q <= 1'b0;
      end else begin
        idx_q  <= idx_q + stride;
        cnt_q  <= cnt_q + ONE;
        data_q <= lane_x;
      end
    end
  end

  // A restart or a disable in the same cycle swallows the final acceptance.
  assign done      = en & ~start & (state_q == RUN) & accept & last;
  assign busy      = (state_q == RUN);
  assign dbg_state = state_q;

  assign stream.out_data  = data_q;
  assign stream.out_idx   = idx_q;
  assign stream.out_valid = valid_q;

endmodule

// File: tb/tb_sobol_gen_param.sv
module tb_sobol_gen_param;
  import sobol_pkg::*;

  localparam int W = 6;
  localparam int D = 2;

  // clock / reset / inputs
  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             en = 1'b0;
  logic             start = 1'b0;
  logic [1:0]       mode = '0;
  logic [W-1:0]     len = '0;
  logic [D*W*W-1:0] dir = '0;
  logic             busy, done;
  state_t           dbg_state;

  sobol_gen_param_if #(.W(W), .D(D)) sif ();

  always #5 clk = ~clk;

  sobol_gen_param #(.W(W), .D(D)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .start     (start),
    .mode      (mode),
    .len       (len),
    .dir       (dir),
    .stream    (sif),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state)
  );

  int checks = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  // reference model: what the consumer should observe
  bit           m_valid, m_busy, m_zero;
  int           m_idx, m_cnt, m_len;
  logic [1:0]   m_mode;
  logic [W-1:0] m_dir[D][W];

  function automatic int sample(input int d, input int n);
    int g, x;
    g = m_mode[MODE_GRAY] ? (n ^ (n >> 1)) : n;
    x = 0;
    for (int k = 0; k < W; k++)
      if (((g >> k) & 1) == 1) x = x ^ int'(m_dir[d][k]);
    return x % (1 << W);
  endfunction

  function automatic bit exp_done();
    return en && !start && m_valid && sif.out_ready && (m_len != 0) && (m_cnt + 1 == m_len);
  endfunction

  task automatic model_reset();
    m_valid = 0; m_busy = 0; m_zero = 1; m_idx = 0; m_cnt = 0; m_len = 0; m_mode = '0;
    for (int d = 0; d < D; d++) for (int k = 0; k < W; k++) m_dir[d][k] = '0;
  endtask

  task automatic model_step();
    bit acc;
    acc = m_valid && sif.out_ready;
    if (!en) begin
      m_valid = 0; m_busy = 0; m_zero = 1; m_idx = 0; m_cnt = 0;
    end else if (start) begin
      m_mode = mode; m_len = int'(len);
      for (int d = 0; d < D; d++)
        for (int k = 0; k < W; k++) m_dir[d][k] = dir[(d*W+k)*W +: W];
      m_idx = mode[MODE_ODD] ? 1 : 0; m_cnt = 0;
      m_valid = 1; m_busy = 1; m_zero = 0;
    end else if (acc) begin
      if (m_len != 0 && m_cnt + 1 == m_len) begin
        m_valid = 0; m_busy = 0;
      end else begin
        m_idx = (m_idx + (m_mode[MODE_ODD] ? 2 : 1)) % (1 << W);
        m_cnt++;
      end
    end
  endtask

  task automatic check_outputs();
    check_val("valid", sif.out_valid, m_valid);
    check_val("busy", busy, m_busy);
    check_val("state", dbg_state, m_busy ? RUN : IDLE);
    if (m_valid) begin
      check_val("idx", sif.out_idx, m_idx);
      for (int d = 0; d < D; d++) check_val("data", sif.out_data[d*W +: W], sample(d, m_idx));
    end else if (m_zero) begin
      check_val("idx_zero", sif.out_idx, 0);
      check_val("data_zero", sif.out_data, 0);
    end
  endtask

  // driver: inputs set at the negedge, then one full clock
  task automatic tick();
    #1;
    check_val("done", done, exp_done());
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic scramble_dir();
    for (int b = 0; b < D*W*W; b++) dir[b] = 1'($urandom_range(0, 1));
  endtask

  task automatic load_basic_dir();
    scramble_dir();
    for (int k = 0; k < W; k++) dir[k*W +: W] = W'(1 << (W - 1 - k));
  endtask

  task automatic cfg_random();
    scramble_dir();
    mode = 2'($urandom_range(0, 3));
    len  = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom_range(1, 12));
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  int nat_exp[4]  = '{0, 32, 16, 48};
  int gray_exp[4] = '{0, 32, 48, 16};

  initial begin
    model_reset();
    sif.out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_outputs();
    check_val("reset_done", done, 0);
    rst = 1'b1;
    en  = 1'b1;
    @(negedge clk);

    // natural ordering, len 4
    load_basic_dir(); mode = 2'b00; len = W'(4); sif.out_ready = 1'b1;
    do_start();
    for (int i = 0; i < 4; i++) begin
      check_val("nat_idx", sif.out_idx, i);
      check_val("nat_data", sif.out_data[W-1:0], nat_exp[i]);
      if (i == 3) begin
        #1 check_val("nat_done", done, 1);
      end
      tick();
    end
    check_val("nat_valid_after", sif.out_valid, 0);
    check_val("nat_busy_after", busy, 0);

    // Gray ordering, len 4
    load_basic_dir(); mode = 2'b01; len = W'(4);
    do_start();
    for (int i = 0; i < 4; i++) begin
      check_val("gray_data", sif.out_data[W-1:0], gray_exp[i]);
      tick();
    end
    check_val("gray_valid_after", sif.out_valid, 0);

    // odd stride, free-running, wrap 63 -> 1
    load_basic_dir(); mode = 2'b10; len = '0;
    do_start();
    for (int i = 0; i < 33; i++) begin
      check_val("odd_idx", sif.out_idx, (2*i + 1) % 64);
      check_val("odd_busy", busy, 1);
      tick();
    end
    en = 1'b0; tick(); en = 1'b1;

    // backpressure for 5 cycles mid-run
    load_basic_dir(); mode = 2'b00; len = W'(20);
    do_start();
    repeat (4) tick();
    sif.out_ready = 1'b0;
    repeat (5) tick();
    check_val("bp_idx_held", sif.out_idx, 4);
    sif.out_ready = 1'b1;
    tick();
    check_val("bp_idx_next", sif.out_idx, 5);
    for (int c = 0; c < 40 && m_busy; c++) tick();
    check_val("bp_finished", busy, 0);

    // en low mid-run
    cfg_random(); len = '0;
    do_start();
    repeat (3) tick();
    en = 1'b0; tick(); en = 1'b1;
    check_val("en_low_valid", sif.out_valid, 0);
    check_val("en_low_state", dbg_state, IDLE);

    // reset mid-run
    cfg_random(); len = '0;
    do_start();
    repeat (3) tick();
    #2 rst = 1'b0;
    #1;
    check_val("rst_valid", sif.out_valid, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_idx", sif.out_idx, 0);
    check_val("rst_data", sif.out_data, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    check_outputs();

    // restart during a run
    load_basic_dir(); mode = 2'b00; len = W'(10);
    do_start();
    repeat (3) tick();
    mode = 2'b10;
    do_start();
    check_val("restart_idx", sif.out_idx, 1);
    for (int c = 0; c < 40 && m_busy; c++) tick();

    // randomized runs with config noise, restarts and disables
    for (int r = 0; r < 20; r++) begin
      cfg_random();
      do_start();
      for (int c = 0; c < 60; c++) begin
        int roll;
        if (!m_busy) break;
        sif.out_ready = ($urandom_range(0, 3) != 0);
        mode = 2'($urandom_range(0, 3));
        len  = W'($urandom_range(0, 63));
        scramble_dir();
        roll = $urandom_range(0, 99);
        if (roll < 3) begin
          cfg_random();
          do_start();
        end else if (roll < 5) begin
          en = 1'b0; tick(); en = 1'b1;
        end else begin
          tick();
        end
      end
      if (m_busy) begin
        en = 1'b0; tick(); en = 1'b1;
      end
      sif.out_ready = 1'($urandom_range(0, 1));
      repeat (2) tick();
      sif.out_ready = 1'b1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
